// File: rtl/level_sequencer.sv
// Level progression controller: owns the level number, runs the
// frame-counted level-up blink transition, and handles win/game over.
module level_sequencer #(
    parameter int MAX_LEVEL      = 9,
    parameter int LEVELUP_FRAMES = 64,
    parameter int BLINK_PERIOD   = 8,
    parameter int FRAME_CNT_W    = 8
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startOfFrame,
    input  logic       levelComplete,
    input  logic       gameOver,
    input  logic       newGame,
    output logic [3:0] level,
    output logic       levelVisible,
    output logic       freezeGame,
    output logic       levelUpActive,
    output logic       levelUpPulse,
    output logic       gameWon
);

    typedef enum logic [1:0] {
        PLAY,
        LEVEL_UP,
        WIN,
        GAME_OVER
    } state_t;

    localparam logic [3:0] LEVEL_MAX = 4'(MAX_LEVEL);
    localparam logic [FRAME_CNT_W-1:0] FRAME_LAST = FRAME_CNT_W'(LEVELUP_FRAMES - 1);
    localparam logic [FRAME_CNT_W-1:0] BLINK_LAST = FRAME_CNT_W'(BLINK_PERIOD - 1);

    state_t                 state, stateNext;
    logic [FRAME_CNT_W-1:0] frameCnt, frameCntNext;
    logic [FRAME_CNT_W-1:0] blinkCnt, blinkCntNext;
    logic [3:0]             levelNext;
    logic                   visibleNext;
    logic                   pulseNext;
    logic                   freezeNext;
    logic                   activeNext;
    logic                   wonNext;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state         <= PLAY;
            level         <= 4'd1;
            levelVisible  <= 1'b1;
            frameCnt      <= '0;
            blinkCnt      <= '0;
            levelUpPulse  <= 1'b0;
            freezeGame    <= 1'b0;
            levelUpActive <= 1'b0;
            gameWon       <= 1'b0;
        end else begin
            state         <= stateNext;
            level         <= levelNext;
            levelVisible  <= visibleNext;
            frameCnt      <= frameCntNext;
            blinkCnt      <= blinkCntNext;
            levelUpPulse  <= pulseNext;
            freezeGame    <= freezeNext;
            levelUpActive <= activeNext;
            gameWon       <= wonNext;
        end
    end

    always_comb begin
        stateNext    = state;
        levelNext    = level;
        visibleNext  = levelVisible;
        frameCntNext = frameCnt;
        blinkCntNext = blinkCnt;
        pulseNext    = 1'b0;
        if (newGame) begin
            stateNext    = PLAY;
            levelNext    = 4'd1;
            visibleNext  = 1'b1;
            frameCntNext = '0;
            blinkCntNext = '0;
        end else begin
            unique case (state)
                PLAY: begin
                    if (gameOver) begin
                        stateNext    = GAME_OVER;
                        visibleNext  = 1'b1;
                        frameCntNext = '0;
                    end else if (levelComplete) begin
                        frameCntNext = '0;
                        blinkCntNext = '0;
                        visibleNext  = 1'b0;
                        if (level < LEVEL_MAX) begin
                            stateNext = LEVEL_UP;
                            levelNext = level + 4'd1;
                            pulseNext = 1'b1;
                        end else begin
                            stateNext = WIN;
                        end
                    end
                end
                LEVEL_UP: begin
                    if (gameOver) begin
                        stateNext    = GAME_OVER;
                        visibleNext  = 1'b1;
                        frameCntNext = '0;
                    end else if (startOfFrame) begin
                        if (frameCnt == FRAME_LAST) begin
                            stateNext    = PLAY;
                            visibleNext  = 1'b1;
                            frameCntNext = '0;
                            blinkCntNext = '0;
                        end else begin
                            frameCntNext = frameCnt + 1'b1;
                            blinkCntNext = blinkCnt + 1'b1;
                            if (blinkCnt == BLINK_LAST) begin
                                blinkCntNext = '0;
                                visibleNext  = ~levelVisible;
                            end
                        end
                    end
                end
                WIN: begin
                    if (startOfFrame) begin
                        blinkCntNext = blinkCnt + 1'b1;
                        if (blinkCnt == BLINK_LAST) begin
                            blinkCntNext = '0;
                            visibleNext  = ~levelVisible;
                        end
                    end
                end
                GAME_OVER: begin
                    visibleNext = 1'b1;
                end
                default: begin
                    stateNext = PLAY;
                end
            endcase
        end
    end

    // Flags are decoded from the next state so they register alongside it.
    always_comb begin
        freezeNext = (stateNext != PLAY);
        activeNext = (stateNext == LEVEL_UP);
        wonNext    = (stateNext == WIN);
    end

endmodule

// File: tb/tb_level_sequencer.sv
// Directed bench for level_sequencer: expected values are hand-computed
// from the default parameters (MAX 9, 64 frames, blink 8).
module tb_level_sequencer;

    localparam logic [3:0] NG = 4'b1000;
    localparam logic [3:0] GO = 4'b0100;
    localparam logic [3:0] LC = 4'b0010;
    localparam logic [3:0] SF = 4'b0001;

    logic       clk = 1'b0;
    logic       resetN;
    logic       startOfFrame, levelComplete, gameOver, newGame;
    logic [3:0] level;
    logic       levelVisible, freezeGame, levelUpActive;
    logic       levelUpPulse, gameWon;

    int total = 0;
    int bad   = 0;

    level_sequencer dut (
        .clk          (clk),
        .resetN       (resetN),
        .startOfFrame (startOfFrame),
        .levelComplete(levelComplete),
        .gameOver     (gameOver),
        .newGame      (newGame),
        .level        (level),
        .levelVisible (levelVisible),
        .freezeGame   (freezeGame),
        .levelUpActive(levelUpActive),
        .levelUpPulse (levelUpPulse),
        .gameWon      (gameWon)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Hold the given event mask for exactly one clock, starting at a negedge.
    task automatic step(input logic [3:0] m);
        {newGame, gameOver, levelComplete, startOfFrame} = m;
        @(negedge clk);
        {newGame, gameOver, levelComplete, startOfFrame} = 4'b0000;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) step(SF);
    endtask

    initial begin
        resetN = 1'b0;
        {newGame, gameOver, levelComplete, startOfFrame} = 4'b0000;
        repeat (3) @(negedge clk);
        resetN = 1'b1;
        @(negedge clk);
        chk("rst_level", level, 1);
        chk("rst_vis", levelVisible, 1);
        chk("rst_freeze", freezeGame, 0);
        chk("rst_active", levelUpActive, 0);
        chk("rst_pulse", levelUpPulse, 0);
        chk("rst_won", gameWon, 0);

        frames(10);
        chk("play_level", level, 1);
        chk("play_vis", levelVisible, 1);
        chk("play_freeze", freezeGame, 0);

        step(LC);
        chk("lu_level", level, 2);
        chk("lu_pulse", levelUpPulse, 1);
        chk("lu_freeze", freezeGame, 1);
        chk("lu_active", levelUpActive, 1);
        chk("lu_vis0", levelVisible, 0);
        step(4'b0000);
        chk("lu_pulse_off", levelUpPulse, 0);
        frames(7);
        chk("lu_vis_f7", levelVisible, 0);
        frames(1);
        chk("lu_vis_f8", levelVisible, 1);
        frames(2);
        step(LC);
        chk("lu_ignore_lc", level, 2);
        chk("lu_ignore_pulse", levelUpPulse, 0);
        frames(6);
        chk("lu_vis_f16", levelVisible, 0);
        frames(47);
        chk("lu_active_f63", levelUpActive, 1);
        chk("lu_freeze_f63", freezeGame, 1);
        frames(1);
        chk("lu_exit_active", levelUpActive, 0);
        chk("lu_exit_freeze", freezeGame, 0);
        chk("lu_exit_vis", levelVisible, 1);
        chk("lu_exit_level", level, 2);

        for (int k = 0; k < 7; k++) begin
            step(LC);
            frames(64);
        end
        chk("lvl9", level, 9);
        chk("lvl9_freeze", freezeGame, 0);

        step(LC);
        chk("win_won", gameWon, 1);
        chk("win_level", level, 9);
        chk("win_pulse", levelUpPulse, 0);
        chk("win_vis0", levelVisible, 0);
        frames(200);
        chk("win_vis200", levelVisible, 1);
        frames(8);
        chk("win_vis208", levelVisible, 0);
        step(GO);
        step(LC);
        chk("win_hold", gameWon, 1);
        chk("win_hold_lvl", level, 9);
        step(NG);
        chk("ng_level", level, 1);
        chk("ng_won", gameWon, 0);
        chk("ng_freeze", freezeGame, 0);

        step(LC);
        frames(64);
        step(LC);
        frames(64);
        chk("lvl3", level, 3);
        step(GO | LC);
        chk("go_level", level, 3);
        chk("go_freeze", freezeGame, 1);
        chk("go_pulse", levelUpPulse, 0);
        chk("go_active", levelUpActive, 0);
        chk("go_vis", levelVisible, 1);
        step(LC);
        frames(3);
        chk("go_hold", level, 3);
        step(NG);
        chk("go_ng_level", level, 1);
        chk("go_ng_freeze", freezeGame, 0);

        step(LC);
        frames(5);
        step(NG | GO);
        chk("ngo_level", level, 1);
        chk("ngo_freeze", freezeGame, 0);
        chk("ngo_active", levelUpActive, 0);
        chk("ngo_vis", levelVisible, 1);

        step(LC);
        frames(30);
        chk("pre_rst_level", level, 2);
        #2 resetN = 1'b0;
        #1;
        chk("arst_level", level, 1);
        chk("arst_vis", levelVisible, 1);
        chk("arst_freeze", freezeGame, 0);
        chk("arst_active", levelUpActive, 0);
        @(negedge clk);
        resetN = 1'b1;
        @(negedge clk);
        chk("arst_after", level, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
